// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (1440x900 @ 60 Hz, 1904x932 totals) and sync-window helpers.
package vga_pkg;

  localparam int unsigned CNT_W = 11;

  localparam int unsigned H_ACTIVE_DEF = 1440;
  localparam int unsigned H_FP_DEF     = 80;
  localparam int unsigned H_SYNC_DEF   = 152;
  localparam int unsigned H_BP_DEF     = 232;

  localparam int unsigned V_ACTIVE_DEF = 900;
  localparam int unsigned V_FP_DEF     = 1;
  localparam int unsigned V_SYNC_DEF   = 3;
  localparam int unsigned V_BP_DEF     = 28;

  localparam int unsigned DRAW_LAT_DEF = 2;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
  } sync_t;

  function automatic int unsigned sync_start(int unsigned active, int unsigned fp);
    return active + fp;
  endfunction

  function automatic int unsigned sync_end(int unsigned active, int unsigned fp,
                                           int unsigned sync);
    return active + fp + sync - 1;
  endfunction

endpackage

// File: rtl/sig_delay.sv
// Fixed-depth shift register with a reset value; depth 0 is a plain wire.
module sig_delay #(
  parameter int unsigned       WIDTH   = 1,
  parameter int unsigned       DEPTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    assign q = d;
  end else begin : g_shift
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      end else begin
        stage[0] <= d;
        for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters, sync generation and colour gating, with the sync path delayed
// to line up with the draw controller's DRAW_LAT-cycle latency.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b1,
  parameter int unsigned DRAW_LAT = DRAW_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic [3:0]  draw_r,
  input  logic [3:0]  draw_g,
  input  logic [3:0]  draw_b,
  output logic [10:0] curr_x,
  output logic [10:0] curr_y,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic        frame_tick
);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_PRE    = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(sync_start(H_ACTIVE, H_FP));
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(sync_end(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(sync_start(V_ACTIVE, V_FP));
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(sync_end(V_ACTIVE, V_FP, V_SYNC));
  localparam sync_t SYNC_IDLE = '{hsync: ~HS_POL, vsync: ~VS_POL, active: 1'b0};

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_last, v_last;
  logic             entered;
  sync_t            raw, dly;

  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);
  assign curr_x = h_cnt;
  assign curr_y = v_cnt;

  // entered marks the cycle in which (0, V_ACTIVE) was just reached, so a held
  // coordinate under pix_en=0 cannot retrigger frame_tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt      <= '0;
      v_cnt      <= '0;
      entered    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= entered;
      entered    <= pix_en && h_last && (v_cnt == V_PRE);
      if (pix_en) begin
        if (h_last) begin
          h_cnt <= '0;
          v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    raw        = SYNC_IDLE;
    raw.hsync  = (h_cnt >= HS_START && h_cnt <= HS_END) ? HS_POL : ~HS_POL;
    raw.vsync  = (v_cnt >= VS_START && v_cnt <= VS_END) ? VS_POL : ~VS_POL;
    raw.active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  end

  sig_delay #(
    .WIDTH   ($bits(sync_t)),
    .DEPTH   (DRAW_LAT),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .clk (clk),
    .rst (rst),
    .d   (raw),
    .q   (dly)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync  <= ~HS_POL;
      vsync  <= ~VS_POL;
      active <= 1'b0;
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
    end else begin
      hsync  <= dly.hsync;
      vsync  <= dly.vsync;
      active <= dly.active;
      vga_r  <= dly.active ? draw_r : '0;
      vga_g  <= dly.active ? draw_g : '0;
      vga_b  <= dly.active ? draw_b : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced 32x16 raster: one DUT at DRAW_LAT=2
// with default polarities, one at DRAW_LAT=0 with both polarities flipped.
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 4, HS = 6, HB = 6;
  localparam int VA = 10, VF = 1, VS = 3, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int LAT = 2;
  localparam logic [14:0] IDLE2 = {1'b1, 1'b0, 1'b0, 12'h000};
  localparam logic [14:0] IDLE0 = {1'b0, 1'b1, 1'b0, 12'h000};

  logic clk = 1'b0, rst = 1'b1, pix_en = 1'b0;
  logic [3:0] dr = '0, dg = '0, db = '0, d0r = '0, d0g = '0, d0b = '0;
  logic [10:0] cx, cy, cx0, cy0;
  logic [3:0] vr, vg, vb, v0r, v0g, v0b;
  logic hs, vs, act, ft, hs0, vs0, act0, ft0;
  logic [14:0] obs, obs0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b1), .DRAW_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .draw_r(dr), .draw_g(dg), .draw_b(db),
    .curr_x(cx), .curr_y(cy),
    .vga_r(vr), .vga_g(vg), .vga_b(vb),
    .hsync(hs), .vsync(vs), .active(act), .frame_tick(ft)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b0), .DRAW_LAT(0)
  ) dut0 (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .draw_r(d0r), .draw_g(d0g), .draw_b(d0b),
    .curr_x(cx0), .curr_y(cy0),
    .vga_r(v0r), .vga_g(v0g), .vga_b(v0b),
    .hsync(hs0), .vsync(vs0), .active(act0), .frame_tick(ft0)
  );

  assign obs  = {hs, vs, act, vr, vg, vb};
  assign obs0 = {hs0, vs0, act0, v0r, v0g, v0b};

  int n_checks = 0, n_fail = 0;
  int mh = 0, mv = 0, ph1 = -1, pv1 = -1, ph2 = -1, pv2 = -1;
  logic [10:0] xh0 = '0, xh1 = '0, yh0 = '0, yh1 = '0;
  logic [14:0] q2[$], q0[$];
  logic [14:0] e2, e0;
  logic tick_exp;

  // Expected registered output for a raster coordinate, given the sync polarities.
  function automatic logic [14:0] model_out(int x, int y, logic hpol, logic vpol);
    logic h_on, v_on, a;
    logic [3:0] xr, yr;
    h_on = (x >= HA + HF) && (x < HA + HF + HS);
    v_on = (y >= VA + VF) && (y < VA + VF + VS);
    a    = (x < HA) && (y < VA);
    xr   = 4'(x);
    yr   = 4'(y);
    return {h_on ? hpol : ~hpol, v_on ? vpol : ~vpol, a,
            a ? xr : 4'h0, a ? yr : 4'h0, a ? (xr ^ yr) : 4'h0};
  endfunction

  // One clock: advance the model, play the draw controller, push the new coordinate's
  // expected output and pop the one due now.
  task automatic cycle();
    @(posedge clk);
    ph2 = ph1; pv2 = pv1; ph1 = mh; pv1 = mv;
    if (rst) begin
      mh = 0; mv = 0; ph1 = -1; pv1 = -1; ph2 = -1; pv2 = -1;
      q2.delete(); q0.delete();
      repeat (LAT + 1) q2.push_back(IDLE2);
      q0.push_back(IDLE0);
    end else if (pix_en) begin
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
    end
    #1;
    dr = xh1[3:0]; dg = yh1[3:0]; db = xh1[3:0] ^ yh1[3:0];
    xh1 = xh0; yh1 = yh0; xh0 = cx; yh0 = cy;
    d0r = cx0[3:0]; d0g = cy0[3:0]; d0b = cx0[3:0] ^ cy0[3:0];
    @(negedge clk);
    q2.push_back(model_out(mh, mv, 1'b0, 1'b1));
    q0.push_back(model_out(mh, mv, 1'b1, 1'b0));
    e2 = q2.pop_front();
    e0 = q0.pop_front();
    tick_exp = (ph1 == 0 && pv1 == VA) && !(ph2 == 0 && pv2 == VA);
  endtask

  task automatic test_reset();
    rst = 1'b1; pix_en = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
    if ({cx, cy} !== 22'd0) begin n_fail++; $display("FAIL reset_coord got=%0d,%0d exp=0,0", cx, cy); end
    if (obs !== IDLE2) begin n_fail++; $display("FAIL reset_out got=%h exp=%h", obs, IDLE2); end
    if (obs0 !== IDLE0) begin n_fail++; $display("FAIL reset_out0 got=%h exp=%h", obs0, IDLE0); end
    if ({ft, ft0} !== 2'b00) begin n_fail++; $display("FAIL reset_tick got=%b%b exp=00", ft, ft0); end
    n_checks += 4;
  endtask

  task automatic test_line();
    int hs_low = 0, max_x = 0;
    pix_en = 1'b1;
    for (int i = 0; i < HT; i++) begin
      cycle();
      if (obs !== e2) begin n_fail++; $display("FAIL line_out got=%h exp=%h t=%0t", obs, e2, $time); end
      if (obs0 !== e0) begin n_fail++; $display("FAIL line_out0 got=%h exp=%h t=%0t", obs0, e0, $time); end
      if ({cx, cy, cx0, cy0} !== {2{11'(mh), 11'(mv)}}) begin n_fail++; $display("FAIL line_coord got=%0d,%0d exp=%0d,%0d", cx, cy, mh, mv); end
      n_checks += 3;
      if (!hs) hs_low++;
      if (int'(cx) > max_x) max_x = int'(cx);
    end
    if ({cx, cy} !== {11'd0, 11'd1}) begin n_fail++; $display("FAIL line_wrap got=%0d,%0d exp=0,1", cx, cy); end
    if (max_x != HT - 1) begin n_fail++; $display("FAIL line_max_x got=%0d exp=%0d", max_x, HT - 1); end
    if (hs_low != HS) begin n_fail++; $display("FAIL line_hsync_width got=%0d exp=%0d", hs_low, HS); end
    n_checks += 3;
  endtask

  task automatic test_frame();
    int t1 = -1, t2 = -1, vs_cnt = 0, tk_cnt = 0, pcx = 0, pcy = 0;
    pix_en = 1'b1;
    for (int i = 0; i < 3 * FRAME && t2 < 0; i++) begin
      pcx = int'(cx); pcy = int'(cy);
      cycle();
      if (obs !== e2) begin n_fail++; $display("FAIL frame_out got=%h exp=%h t=%0t", obs, e2, $time); end
      if (obs0 !== e0) begin n_fail++; $display("FAIL frame_out0 got=%h exp=%h t=%0t", obs0, e0, $time); end
      if ({ft, ft0} !== {2{tick_exp}}) begin n_fail++; $display("FAIL frame_tick got=%b%b exp=%b t=%0t", ft, ft0, tick_exp, $time); end
      if ({cx, cy, cx0, cy0} !== {2{11'(mh), 11'(mv)}}) begin n_fail++; $display("FAIL frame_coord got=%0d,%0d exp=%0d,%0d", cx, cy, mh, mv); end
      n_checks += 4;
      if (ft) begin
        if (t1 < 0) begin
          t1 = i;
          if (pcx != 0 || pcy != VA) begin n_fail++; $display("FAIL frame_tick_pos got=%0d,%0d exp=0,%0d", pcx, pcy, VA); end
          n_checks++;
        end else begin
          t2 = i;
        end
      end
      if (t1 >= 0 && t2 < 0) begin vs_cnt += int'(vs); tk_cnt += int'(ft); end
    end
    if (t2 < 0) begin n_fail++; $display("FAIL frame_timeout got=%0d,%0d exp=two ticks", t1, t2); end
    if (t2 - t1 != FRAME) begin n_fail++; $display("FAIL frame_period got=%0d exp=%0d", t2 - t1, FRAME); end
    if (vs_cnt != VS * HT) begin n_fail++; $display("FAIL frame_vsync_width got=%0d exp=%0d", vs_cnt, VS * HT); end
    if (tk_cnt != 1) begin n_fail++; $display("FAIL frame_tick_count got=%0d exp=1", tk_cnt); end
    n_checks += 4;
  endtask

  task automatic test_pix_en_toggle();
    int t1 = -1, t2 = -1, tk_cnt = 0;
    logic prev_ft = 1'b0;
    for (int i = 0; i < 6 * FRAME && t2 < 0; i++) begin
      pix_en = (i % 2 == 0);
      cycle();
      if (obs !== e2) begin n_fail++; $display("FAIL toggle_out got=%h exp=%h t=%0t", obs, e2, $time); end
      if (obs0 !== e0) begin n_fail++; $display("FAIL toggle_out0 got=%h exp=%h t=%0t", obs0, e0, $time); end
      if ({ft, ft0} !== {2{tick_exp}}) begin n_fail++; $display("FAIL toggle_tick got=%b%b exp=%b t=%0t", ft, ft0, tick_exp, $time); end
      if ({cx, cy, cx0, cy0} !== {2{11'(mh), 11'(mv)}}) begin n_fail++; $display("FAIL toggle_coord got=%0d,%0d exp=%0d,%0d", cx, cy, mh, mv); end
      if (ft && prev_ft) begin n_fail++; $display("FAIL toggle_tick_width got=2+ cycles exp=1 t=%0t", $time); end
      n_checks += 5;
      prev_ft = ft;
      if (ft) begin
        if (t1 < 0) t1 = i;
        else t2 = i;
      end
      if (t1 >= 0 && t2 < 0) tk_cnt += int'(ft);
    end
    pix_en = 1'b1;
    if (t2 - t1 != 2 * FRAME) begin n_fail++; $display("FAIL toggle_period got=%0d exp=%0d", t2 - t1, 2 * FRAME); end
    if (tk_cnt != 1) begin n_fail++; $display("FAIL toggle_tick_count got=%0d exp=1", tk_cnt); end
    n_checks += 2;
  endtask

  task automatic test_mid_reset();
    int since = 0;
    bit found = 0;
    pix_en = 1'b1;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      cycle();
      if (obs !== e2) begin n_fail++; $display("FAIL midrst_out got=%h exp=%h t=%0t", obs, e2, $time); end
      n_checks++;
      found = (cx == 11'd7 && cy == 11'd5);
    end
    if (!found) begin n_fail++; $display("FAIL midrst_seek_timeout got=%0d,%0d exp=7,5", cx, cy); end
    n_checks++;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    if ({cx, cy, cx0, cy0} !== 44'd0) begin n_fail++; $display("FAIL midrst_coord got=%0d,%0d exp=0,0", cx, cy); end
    if (obs !== IDLE2) begin n_fail++; $display("FAIL midrst_out_rst got=%h exp=%h", obs, IDLE2); end
    if (obs0 !== IDLE0) begin n_fail++; $display("FAIL midrst_out0_rst got=%h exp=%h", obs0, IDLE0); end
    if ({ft, ft0} !== 2'b00) begin n_fail++; $display("FAIL midrst_tick_rst got=%b%b exp=00", ft, ft0); end
    n_checks += 4;
    for (int k = 1; k <= LAT + 1; k++) begin
      cycle();
      if (k == 1 && {act0, v0r} !== 5'b1_0000) begin n_fail++; $display("FAIL midrst_lat0_first got=%b,%h exp=1,0", act0, v0r); end
      if (k <= LAT && act !== 1'b0) begin n_fail++; $display("FAIL midrst_fill got=%b exp=0 k=%0d", act, k); end
      if (k == LAT + 1 && {act, vr, vg, vb} !== 13'h1000) begin n_fail++; $display("FAIL midrst_first_pixel got=%b,%h%h%h exp=1,000", act, vr, vg, vb); end
      n_checks += 1;
    end
    since = LAT + 1;
    found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      cycle();
      since++;
      if (obs !== e2) begin n_fail++; $display("FAIL midrst_run_out got=%h exp=%h t=%0t", obs, e2, $time); end
      if (obs0 !== e0) begin n_fail++; $display("FAIL midrst_run_out0 got=%h exp=%h t=%0t", obs0, e0, $time); end
      n_checks += 2;
      found = ft;
    end
    if (since != VA * HT + 1) begin n_fail++; $display("FAIL midrst_first_tick got=%0d exp=%0d", since, VA * HT + 1); end
    n_checks++;
  endtask

  task automatic test_lat0();
    int px, py;
    pix_en = 1'b1;
    for (int i = 0; i < 2 * HT; i++) begin
      px = mh; py = mv;
      cycle();
      if (v0r !== ((px < HA && py < VA) ? 4'(px) : 4'h0)) begin n_fail++; $display("FAIL lat0_vga_r got=%h exp_x=%0d t=%0t", v0r, px, $time); end
      if (act0 !== (px < HA && py < VA)) begin n_fail++; $display("FAIL lat0_active got=%b exp_x=%0d y=%0d", act0, px, py); end
      n_checks += 2;
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_pix_en_toggle();
    test_mid_reset();
    test_lat0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 1440: visible pixels per line.
REQ-002 Parameter H_FP, default 80: horizontal front porch, in pixels.
REQ-003 Parameter H_SYNC, default 152: hsync pulse width, in pixels.
REQ-004 Parameter H_BP, default 232: horizontal back porch; line total is 1904.
REQ-005 Parameter V_ACTIVE, default 900: visible lines.
REQ-006 Parameter V_FP, default 1: vertical front porch, in lines.
REQ-007 Parameter V_SYNC, default 3: vsync pulse width, in lines.
REQ-008 Parameter V_BP, default 28: vertical back porch; frame total is 932.
REQ-009 Parameter HS_POL, default 0: hsync asserted level; 0 means active-low.
REQ-010 Parameter VS_POL, default 1: vsync asserted level.
REQ-011 Parameter DRAW_LAT, default 2: clk cycles from curr_x/curr_y to valid draw_r/g/b; range 0..7.
REQ-012 clk  in  1  single clock for all logic.
REQ-013 rst  in  1  reset; synchronous, active-high.
REQ-014 pix_en  in  1  pixel advance enable; tied high in normal use.
REQ-015 draw_r, draw_g, draw_b  in  4 each  pixel colour returned by the draw controller.
REQ-016 curr_x  out  11  current horizontal count, 0..1903.
REQ-017 curr_y  out  11  current vertical count, 0..931.
REQ-018 vga_r, vga_g, vga_b  out  4 each  colour driven to the DAC.
REQ-019 hsync, vsync  out  1 each  sync pulses, polarity set by HS_POL/VS_POL.
REQ-020 active  out  1  high when vga_r/g/b carry a visible pixel.
REQ-021 frame_tick  out  1  one-cycle pulse at the start of vertical blanking.

Function
REQ-022 The horizontal counter h_cnt SHALL increment only on cycles with pix_en=1, and wrap from 1903 to 0.
REQ-023 The vertical counter v_cnt SHALL increment only on pix_en cycles where h_cnt wraps, and wrap from 931 to 0.
REQ-024 curr_x/curr_y SHALL equal h_cnt/v_cnt directly, with no added latency.
REQ-025 Raw hsync SHALL be asserted when h_cnt is in [1520, 1671].
REQ-026 Raw vsync SHALL be asserted when v_cnt is in [901, 903].
REQ-027 Raw active SHALL be high when h_cnt < 1440 and v_cnt < 900.
REQ-028 Raw hsync, vsync and active SHALL pass through a DRAW_LAT-stage delay line that advances every clk cycle, independent of pix_en.
REQ-029 A final register SHALL drive hsync, vsync, active and vga_r/g/b together; vga_* = delayed active ? draw_* : 0.
REQ-030 Total latency SHALL be DRAW_LAT+1 cycles: the draw_* value sampled DRAW_LAT cycles after a coordinate appears on curr_x/curr_y is output with that coordinate's syncs.
REQ-031 frame_tick SHALL be high for exactly one clk cycle, in the cycle after (h_cnt, v_cnt) becomes (0, 900); it is not delayed by DRAW_LAT.
REQ-032 With pix_en=0, the counters SHALL hold and the delay line SHALL keep shifting held values; no extra frame_tick SHALL be generated.
REQ-033 Counter compares SHALL be 11-bit unsigned, with no truncation at 1903 or 931.

Reset
REQ-034 While rst=1 at a clk edge: h_cnt=0, v_cnt=0, vga_r/g/b=0, active=0, frame_tick=0, and hsync/vsync at their deasserted levels.
REQ-035 Reset SHALL clear every delay-line stage to active=0 and syncs deasserted.
REQ-036 Reset asserted mid-frame SHALL give curr_x=0, curr_y=0 in the cycle after the edge; the first frame_tick follows at (0, 900) of the new frame.

Structure
REQ-037 The timing constants (1440/80/152/232, 900/1/3/28) and their derived sync start/end values SHALL live in a shared package, vga_pkg.
REQ-038 The delay line SHALL be one sub-module, sig_delay, parameterised by width and depth, with depth 0 meaning a pass-through.

Verification
REQ-039 Reset, then pix_en=1 for 1904 cycles -> curr_x runs 0..1903, curr_y goes 0->1, hsync low for exactly 152 cycles.
REQ-040 Run one full frame -> frame_tick is high once, the cycle after curr_y=900, curr_x=0; vsync high for 3*1904 cycles; period is 1774528 cycles.
REQ-041 DRAW_LAT=2, draw_r = curr_x[3:0] delayed 2 cycles -> vga_r equals the pixel's x[3:0] with active=1 at x<1440; vga_r=0 at x>=1440.
REQ-042 pix_en toggling 1/0 -> counters advance every other cycle; frame period doubles; frame_tick stays a single cycle.
REQ-043 rst pulsed at curr_x=700, curr_y=450 -> next cycle all outputs are at reset values; after DRAW_LAT+1 cycles active=1 for pixel (0,0).
REQ-044 DRAW_LAT=0 -> vga_* lags curr_x by exactly 1 cycle.
